mem_copy_engine: RTL and testbench
==================================

# mem_copy_engine

Bus-master copy engine that drives the single-port data memory interface (shared address, combinational read, clock-edge write) to move a block of bytes from one address range to another. It sits beside the core as the initiator on the data memory port. The memory side is muxed in by the integrating level while `busy` is high. One byte is copied every two cycles: a read cycle, then a write cycle.

## Interface
Parameters:
- `ADDR_W`, 8: memory address width; all address arithmetic is modulo 2^ADDR_W.
- `DATA_W`, 8: memory word width.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE immediately.
- `start`  in  1  request a copy; sampled only in IDLE.
- `src_addr`  in  ADDR_W  first source address; captured when `start` is accepted.
- `dst_addr`  in  ADDR_W  first destination address; captured when `start` is accepted.
- `length`  in  ADDR_W  byte count, 0..255; captured when `start` is accepted. A value of 0 means no transfer.
- `busy`  out  1  high from the cycle after acceptance through the DONE cycle.
- `done`  out  1  one-cycle pulse on completion.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_read`  out  1  read enable.
- `mem_write`  out  1  write enable.
- `write_value`  out  DATA_W  write data.
- `read_value`  in  DATA_W  memory read data; valid only while `mem_read` is high.

## Operation
- Registers: `src_q`, `dst_q`, `cnt_q` (bytes remaining), `buf_q` (DATA_W).
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - `start` with `length` != 0: capture the inputs, go to READ.
  - `start` with `length` == 0: go to DONE.
  - Otherwise stay in IDLE.
- READ:
  - Drive `mem_addr` = `src_q` and `mem_read` = 1.
  - At the clock edge, load `buf_q` <= `read_value` and go to WRITE.
- WRITE:
  - Drive `mem_addr` = `dst_q`, `mem_write` = 1, `write_value` = `buf_q`.
  - At the clock edge: `src_q`++, `dst_q`++ (wrapping 255 -> 0), `cnt_q`--.
  - If `cnt_q` was 1, go to DONE; otherwise go to READ.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- `mem_read` and `mem_write` are never high in the same cycle.
- Outside READ and WRITE, `mem_read` = 0 and `mem_write` = 0.
- In IDLE and DONE, `mem_addr` and `write_value` are held at 0.
- `start` is ignored in READ, WRITE and DONE. A new `start` is accepted in the IDLE cycle right after DONE.
- Copy is always forward and byte-serial. Overlapping ranges with `dst` inside (`src`, `src`+`length`) therefore replicate the leading bytes. This is the required behaviour.
- Reset mid-operation:
  - The FSM returns to IDLE and all outputs are forced to their reset values immediately.
  - No further write occurs. Bytes already written remain in memory.

## Timing
- Reset values: `busy`=0, `done`=0, `mem_addr`=0, `mem_read`=0, `mem_write`=0, `write_value`=0; all internal registers are 0.
- All outputs decode from registered state only. There is no combinational path from `start`, `src_addr`, `dst_addr` or `length` to any output.
- Start accepted at edge E:
  - First READ cycle is E+1.
  - `done` is high in cycle E+2·N+1 for N = `length`.
  - A zero-length request gives `done` at E+1.
- Memory-side timing:
  - `read_value` must settle within the READ cycle, since the memory read is combinational.
  - The memory captures the write at the edge that ends the WRITE cycle.

## Configuration
- `MEM_COPY_CHECKSUM_EN` defined:
  - Adds output port `checksum` (DATA_W), the modulo-2^DATA_W sum of all bytes written.
  - `checksum` clears to 0 on start acceptance and on reset, and updates at each WRITE edge.
  - It is stable from the DONE cycle until the next accepted start.
- `MEM_COPY_CHECKSUM_EN` undefined: the port and its adder are absent; all other behaviour is identical.

## Test plan
- Basic copy: preload mem[0x10..0x13] = 0x11, 0x22, 0x33, 0x44; start with `src`=0x10, `dst`=0x80, `length`=4 -> mem[0x80..0x83] matches, `done` at E+9, `busy` high for 9 cycles; with checksum enabled, `checksum` = 0xAA.
- Wrap-around: `src`=0xFE, `dst`=0x02, `length`=3 with mem[0xFE]=0xA1, mem[0xFF]=0xB2, mem[0x00]=0xC3 -> mem[0x02..0x04] = 0xA1, 0xB2, 0xC3.
- Zero length: `length`=0 -> `done` at E+1, `mem_write` never asserts, memory unchanged.
- Overlap: mem[0x20..0x23] = 1, 2, 3, 4; `src`=0x20, `dst`=0x21, `length`=3 -> mem[0x21..0x23] = 1, 1, 1.
- Busy and back-to-back: pulse `start` with new operands during WRITE -> ignored, first copy unaffected; assert `start` in the cycle after `done` -> second copy accepted.
- Reset mid-copy: assert `reset` during the 3rd WRITE cycle of an 8-byte copy -> outputs return to 0 immediately, only 2 destination bytes are modified, and the next start runs normally.

Source files
------------

// File: rtl/mem_copy_engine_if.sv
// Command and data-memory bundle for mem_copy_engine.
// Ports: start/src_addr/dst_addr/length in, busy/done out, plus a single-port
// memory bus (mem_addr, mem_read, mem_write, write_value, read_value).
// MEM_COPY_CHECKSUM_EN adds the checksum signal.
interface mem_copy_engine_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W-1:0] length;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] write_value;
    logic [DATA_W-1:0] read_value;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    // engine side: bus master on the memory port
    modport master (
        input  start, src_addr, dst_addr, length, read_value,
`ifdef MEM_COPY_CHECKSUM_EN
        output checksum,
`endif
        output busy, done, mem_addr, mem_read, mem_write, write_value
    );

    // requester + memory side
    modport slave (
        output start, src_addr, dst_addr, length, read_value,
`ifdef MEM_COPY_CHECKSUM_EN
        input  checksum,
`endif
        input  busy, done, mem_addr, mem_read, mem_write, write_value
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Byte-serial block copy engine: one READ cycle then one WRITE cycle per byte.
// Ports: clk, reset (async, active-high), bus (mem_copy_engine_if.master).
// Optional MEM_COPY_CHECKSUM_EN adds bus.checksum, the mod-2^DATA_W sum of bytes written.
module mem_copy_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    mem_copy_engine_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] buf_q, buf_d;

    // outputs are registered: *_d holds the value for the state being entered
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [DATA_W-1:0] write_value_q, write_value_d;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        dst_d         = dst_q;
        cnt_d         = cnt_q;
        buf_d         = buf_q;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        mem_addr_d    = '0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        write_value_d = '0;
`ifdef MEM_COPY_CHECKSUM_EN
        checksum_d    = checksum_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
`ifdef MEM_COPY_CHECKSUM_EN
                    checksum_d = '0;
`endif
                    busy_d = 1'b1;
                    if (bus.length != '0) begin
                        src_d      = bus.src_addr;
                        dst_d      = bus.dst_addr;
                        cnt_d      = bus.length;
                        state_d    = READ;
                        mem_addr_d = bus.src_addr;
                        mem_read_d = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            READ: begin
                buf_d         = bus.read_value;
                state_d       = WRITE;
                busy_d        = 1'b1;
                mem_addr_d    = dst_q;
                mem_write_d   = 1'b1;
                write_value_d = bus.read_value;
            end
            WRITE: begin
                src_d  = src_q + ADDR_W'(1);
                dst_d  = dst_q + ADDR_W'(1);
                cnt_d  = cnt_q - ADDR_W'(1);
                busy_d = 1'b1;
`ifdef MEM_COPY_CHECKSUM_EN
                checksum_d = checksum_q + buf_q;
`endif
                if (cnt_q == ADDR_W'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d    = READ;
                    mem_addr_d = src_q + ADDR_W'(1);
                    mem_read_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            src_q         <= '0;
            dst_q         <= '0;
            cnt_q         <= '0;
            buf_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mem_addr_q    <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            write_value_q <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
            checksum_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            cnt_q         <= cnt_d;
            buf_q         <= buf_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            mem_addr_q    <= mem_addr_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            write_value_q <= write_value_d;
`ifdef MEM_COPY_CHECKSUM_EN
            checksum_q    <= checksum_d;
`endif
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.write_value = write_value_q;
`ifdef MEM_COPY_CHECKSUM_EN
    assign bus.checksum    = checksum_q;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine against a forward byte-copy model.
// Covers basic, wrap, zero-length, overlap, busy/back-to-back, reset mid-copy, random.
module tb_mem_copy_engine;

    logic clk;
    logic reset;

    mem_copy_engine_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-port memory: combinational read, write at clock edge
    logic [7:0] mem [256];
    logic       tb_we;
    logic [7:0] tb_addr;
    logic [7:0] tb_data;

    assign bus.read_value = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (tb_we)
            mem[tb_addr] <= tb_data;
        else if (bus.mem_write)
            mem[bus.mem_addr] <= bus.write_value;
    end

    int vectors;
    int miscompares;

    typedef struct {
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [7:0]  len;
        logic [7:0]  p_addr;
        int          p_n;
        logic [31:0] p_data;
        logic [7:0]  e_addr;
        int          e_n;
        logic [31:0] e_data;
        bit          inj;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we   = 1'b1;
        tb_addr = a;
        tb_data = d;
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    function automatic int outs_packed();
        return {bus.busy, bus.done, bus.mem_read, bus.mem_write,
                bus.mem_addr, bus.write_value};
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        logic [7:0] rm [256];
        logic [7:0] sum;
        logic [7:0] a;
        logic [7:0] b;
        int done_at;
        int bcnt;
        int wcnt;
        int bad;
        bit both;
        for (int i = 0; i < v.p_n; i++) begin
            a = v.p_addr + 8'(i);
            poke(a, v.p_data[8*i +: 8]);
        end
        // reference: forward byte-serial copy on a snapshot of memory
        rm  = mem;
        sum = '0;
        for (int i = 0; i < int'(v.len); i++) begin
            a = v.src + 8'(i);
            b = rm[a];
            a = v.dst + 8'(i);
            rm[a] = b;
            sum   = sum + b;
        end
        @(negedge clk);
        chk({tag, " idle_outs"}, outs_packed(), 0);
        bus.start    = 1'b1;
        bus.src_addr = v.src;
        bus.dst_addr = v.dst;
        bus.length   = v.len;
        @(posedge clk);
        #1 bus.start = 1'b0;
        done_at = -1;
        bcnt = 0;
        wcnt = 0;
        both = 1'b0;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (v.inj && c == 2) begin
                bus.start    = 1'b1;
                bus.src_addr = ~v.src;
                bus.dst_addr = v.src;
                bus.length   = 8'd1;
            end
            if (v.inj && c == 3)
                bus.start = 1'b0;
            if (bus.busy) bcnt++;
            if (bus.mem_write) wcnt++;
            if (bus.mem_read && bus.mem_write) both = 1'b1;
            if (bus.done) begin
                done_at = c;
                break;
            end
        end
        chk({tag, " done_latency"}, done_at, 2 * int'(v.len) + 1);
        chk({tag, " busy_cycles"}, bcnt, 2 * int'(v.len) + 1);
        chk({tag, " write_count"}, wcnt, int'(v.len));
        chk({tag, " rd_wr_exclusive"}, int'(both), 0);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== rm[i]) bad++;
        chk({tag, " mem_bad_bytes"}, bad, 0);
        if (v.e_n > 0) begin
            bad = 0;
            for (int i = 0; i < v.e_n; i++) begin
                a = v.e_addr + 8'(i);
                if (mem[a] !== v.e_data[8*i +: 8]) bad++;
            end
            chk({tag, " expected_bytes"}, bad, 0);
        end
`ifdef MEM_COPY_CHECKSUM_EN
        chk({tag, " checksum"}, int'(bus.checksum), int'(sum));
`endif
    endtask

    function automatic vec_t mk(input logic [7:0] s, input logic [7:0] d,
                                input logic [7:0] l, input bit inj);
        vec_t v;
        v.src = s; v.dst = d; v.len = l;
        v.p_addr = 8'h00; v.p_n = 0; v.p_data = '0;
        v.e_addr = 8'h00; v.e_n = 0; v.e_data = '0;
        v.inj = inj;
        return v;
    endfunction

    initial begin
        vec_t v;
        logic [7:0] rm [256];
        logic [7:0] a;
        int bad;
        vectors     = 0;
        miscompares = 0;
        tb_we       = 1'b0;
        tb_addr     = '0;
        tb_data     = '0;
        bus.start    = 1'b0;
        bus.src_addr = '0;
        bus.dst_addr = '0;
        bus.length   = '0;

        v = mk(8'h10, 8'h80, 8'd4, 1'b0);
        v.p_addr = 8'h10; v.p_n = 4; v.p_data = 32'h44332211;
        v.e_addr = 8'h80; v.e_n = 4; v.e_data = 32'h44332211;
        vt.push_back(v);
        v = mk(8'hFE, 8'h02, 8'd3, 1'b0);
        v.p_addr = 8'hFE; v.p_n = 3; v.p_data = 32'h00C3B2A1;
        v.e_addr = 8'h02; v.e_n = 3; v.e_data = 32'h00C3B2A1;
        vt.push_back(v);
        vt.push_back(mk(8'h30, 8'h50, 8'd0, 1'b0));
        v = mk(8'h20, 8'h21, 8'd3, 1'b0);
        v.p_addr = 8'h20; v.p_n = 4; v.p_data = 32'h04030201;
        v.e_addr = 8'h21; v.e_n = 3; v.e_data = 32'h00010101;
        vt.push_back(v);
        vt.push_back(mk(8'h60, 8'h70, 8'd3, 1'b1));
        vt.push_back(mk(8'h70, 8'hA0, 8'd2, 1'b0));
        vt.push_back(mk(8'h00, 8'h80, 8'd255, 1'b0));
        vt.push_back(mk(8'hC0, 8'hC0, 8'd1, 1'b0));
        for (int i = 0; i < 10; i++) begin
            v = mk(8'($urandom), 8'($urandom),
                   (i == 4) ? 8'd0 : 8'($urandom_range(1, 24)), 1'b0);
            vt.push_back(v);
        end

        reset = 1'b1;
        #1;
        chk("reset_outs", outs_packed(), 0);
`ifdef MEM_COPY_CHECKSUM_EN
        chk("reset_checksum", int'(bus.checksum), 0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 256; i++)
            poke(8'(i), 8'($urandom));

        foreach (vt[i])
            run_vec(vt[i], $sformatf("v%0d", i));

        // reset during the 3rd WRITE cycle of an 8-byte copy
        for (int i = 0; i < 8; i++)
            poke(8'h40 + 8'(i), 8'hD0 + 8'(i));
        rm = mem;
        for (int i = 0; i < 2; i++) begin
            a = 8'h40 + 8'(i);
            rm[8'h90 + 8'(i)] = rm[a];
        end
        @(negedge clk);
        bus.start    = 1'b1;
        bus.src_addr = 8'h40;
        bus.dst_addr = 8'h90;
        bus.length   = 8'd8;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_pre_write", int'(bus.mem_write), 1);
        reset = 1'b1;
        #1;
        chk("rst_outs_zero", outs_packed(), 0);
`ifdef MEM_COPY_CHECKSUM_EN
        chk("rst_checksum", int'(bus.checksum), 0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (mem[i] !== rm[i]) bad++;
        chk("rst_mem_bad_bytes", bad, 0);

        v = mk(8'h40, 8'hB0, 8'd8, 1'b0);
        run_vec(v, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
